// File: rtl/hx8357_init_sequencer.sv
// HX8357 power-up sequencer: times the RESX pulse off a millisecond prescaler,
// then walks the init ROM and issues each entry as a command/data write or a delay.
module hx8357_init_sequencer #(
    parameter int MS_DIV      = 50000,
    parameter int RST_LOW_MS  = 10,
    parameter int RST_WAIT_MS = 120,
    parameter int ADDR_W      = 8
) (
    input  logic              clk_in,
    input  logic              nres,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic              wr_valid,
    output logic              wr_dc,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              lcd_resx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state    | meaning
    // ---------+--------------------------------------------------
    // IDLE     | waiting for start after reset
    // RST_LOW  | RESX driven low for RST_LOW_MS
    // RST_WAIT | RESX high, panel settling for RST_WAIT_MS
    // FETCH    | rom_addr stable, covers the synchronous ROM latency
    // DECODE   | rom_data sampled and dispatched by kind
    // WRITE    | write request held until accepted
    // DELAY    | waiting payload ms from a DELAY entry
    // DONE     | END reached or ROM overrun; restartable
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_LOW  = 3'd1,
        S_RST_WAIT = 3'd2,
        S_FETCH    = 3'd3,
        S_DECODE   = 3'd4,
        S_WRITE    = 3'd5,
        S_DELAY    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [1:0]  K_CMD   = 2'b00;
    localparam logic [1:0]  K_DATA  = 2'b01;
    localparam logic [1:0]  K_DELAY = 2'b10;

    localparam logic [15:0] PRE_TC  = 16'(MS_DIV - 1);
    localparam logic [15:0] LOW_MS  = 16'(RST_LOW_MS);
    localparam logic [15:0] WAIT_MS = 16'(RST_WAIT_MS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                dc_q, dc_d;
    logic [7:0]          data_q, data_d;
    logic                resx_q, resx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         pre_q, pre_d;
    logic [15:0]         ms_q, ms_d;
    logic [7:0]          dly_q, dly_d;

    logic                timed_q;
    logic                timed_d;
    logic                tick;
    logic [15:0]         target;
    logic [15:0]         target_m1;
    logic                expire;
    logic                advance;
    logic [1:0]          kind;
    logic [7:0]          payload;

    assign kind    = rom_data[9:8];
    assign payload = rom_data[7:0];

    always_comb begin
        target = 16'd0;
        case (state_q)
            S_RST_LOW:  target = LOW_MS;
            S_RST_WAIT: target = WAIT_MS;
            S_DELAY:    target = {8'd0, dly_q};
            default:    target = 16'd0;
        endcase
    end

    // A zero target still waits one full millisecond rather than wrapping.
    assign target_m1 = (target == 16'd0) ? 16'd0 : target - 16'd1;
    assign timed_q   = (state_q == S_RST_LOW) || (state_q == S_RST_WAIT) || (state_q == S_DELAY);
    assign tick      = (pre_q == PRE_TC);
    assign expire    = timed_q && tick && (ms_q >= target_m1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        dc_d    = dc_q;
        data_d  = data_q;
        resx_d  = resx_q;
        err_d   = err_q;
        dly_d   = dly_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RST_LOW;
                    resx_d  = 1'b0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_RST_LOW: begin
                if (expire) begin
                    state_d = S_RST_WAIT;
                    resx_d  = 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (expire) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    K_CMD, K_DATA: begin
                        data_d  = payload;
                        dc_d    = kind[0];
                        valid_d = 1'b1;
                        state_d = S_WRITE;
                    end
                    K_DELAY: begin
                        if (payload == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            dly_d   = payload;
                            state_d = S_DELAY;
                        end
                    end
                    default: begin
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WRITE: begin
                if (valid_q && wr_ready) begin
                    valid_d = 1'b0;
                    advance = 1'b1;
                end
            end
            S_DELAY: begin
                if (expire) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The last ROM slot without an END is treated as an overrun, never a wrap.
        if (advance) begin
            if (addr_q != ADDR_LAST) begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end else begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end
        end
    end

    always_comb begin
        timed_d = (state_d == S_RST_LOW) || (state_d == S_RST_WAIT) || (state_d == S_DELAY);
        pre_d   = 16'd0;
        ms_d    = 16'd0;
        if (timed_d && (state_d == state_q)) begin
            if (tick) begin
                pre_d = 16'd0;
                ms_d  = ms_q + 16'd1;
            end else begin
                pre_d = pre_q + 16'd1;
                ms_d  = ms_q;
            end
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge nres) begin
        if (!nres) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            dc_q    <= 1'b0;
            data_q  <= 8'd0;
            resx_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pre_q   <= 16'd0;
            ms_q    <= 16'd0;
            dly_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            resx_q  <= resx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            dly_q   <= dly_d;
        end
    end

    assign rom_addr = addr_q;
    assign wr_valid = valid_q;
    assign wr_dc    = dc_q;
    assign wr_data  = data_q;
    assign lcd_resx = resx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
